// File: rtl/score_display_pkg.sv
// Shared definitions for the score display: FSM state encodings, default
// parameter values and small BCD helpers used by the top and the decoder.
package score_display_pkg;

    localparam int SCORE_REFRESH_DIV  = 50000;
    localparam int SCORE_SERVE_FRAMES = 60;
    localparam int SCORE_WIN_SCORE    = 9;

    typedef enum logic [1:0] {
        SCORE_IDLE  = 2'd0,
        SCORE_PAUSE = 2'd1,
        SCORE_PLAY  = 2'd2,
        SCORE_OVER  = 2'd3
    } score_state_e;

    // Active-low segments, all dark.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Blink counter value loaded on entering OVER: bit 5 set, so the
    // display starts dark for 32 frames, then shows the score for 32.
    localparam logic [5:0] BLINK_START = 6'd32;

    // Two-digit BCD increment, units carry into tens, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] >= 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Binary 0..99 to packed {tens, units} BCD.
    function automatic logic [7:0] to_bcd(input int v);
        int t;
        int u;
        t = v / 10;
        u = v % 10;
        return {t[3:0], u[3:0]};
    endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Ports: bcd[3:0] in, seg[6:0] out (seg[0]=a .. seg[6]=g); 10..15 are dark.
module seg7_decode
    import score_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Pong score keeper: BCD scores, serve timing, win detection, and a
// multiplexed 4-digit active-low display that blinks when the game ends.
// Ports: clk, rst (sync, active-high), vblank, goal_left, goal_right,
//        new_game in; serve, game_over, winner, seg[6:0], an[3:0] out.
module score_display
    import score_display_pkg::*;
#(
    parameter int REFRESH_DIV  = SCORE_REFRESH_DIV,
    parameter int SERVE_FRAMES = SCORE_SERVE_FRAMES,
    parameter int WIN_SCORE    = SCORE_WIN_SCORE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblank,
    input  logic       goal_left,
    input  logic       goal_right,
    input  logic       new_game,
    output logic       serve,
    output logic       game_over,
    output logic       winner,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (SERVE_FRAMES < 1) ? 1 : $clog2(SERVE_FRAMES + 1);

    localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAMES_LD = FW'(SERVE_FRAMES);
    localparam logic [7:0]    WIN_BCD   = to_bcd(WIN_SCORE);

    score_state_e  state_q, state_d;
    logic [7:0]    left_q, left_d;
    logic [7:0]    right_q, right_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [5:0]    blink_q, blink_d;
    logic          vblank_q;
    logic [RW-1:0] refresh_q, refresh_d;
    logic [1:0]    idx_q, idx_d;
    logic          serve_q, serve_d;
    logic          game_over_q, game_over_d;
    logic          winner_q, winner_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic       vb_rise;
    logic       gl_only;
    logic       gr_only;
    logic [7:0] left_inc;
    logic [7:0] right_inc;
    logic [3:0] digit;
    logic [6:0] seg_dec;
    logic       blank;

    assign vb_rise   = vblank & ~vblank_q;
    assign gl_only   = goal_left & ~goal_right;
    assign gr_only   = goal_right & ~goal_left;
    assign left_inc  = bcd_inc(left_q);
    assign right_inc = bcd_inc(right_q);

    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        right_d     = right_q;
        frame_d     = frame_q;
        blink_d     = blink_q;
        serve_d     = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        if (new_game) begin
            state_d     = SCORE_PAUSE;
            left_d      = 8'h00;
            right_d     = 8'h00;
            frame_d     = FRAMES_LD;
            game_over_d = 1'b0;
            winner_d    = 1'b0;
        end else begin
            unique case (state_q)
                SCORE_IDLE: begin
                end
                SCORE_PAUSE: begin
                    // A count of 0 or 1 means this edge finishes the wait.
                    if (vb_rise) begin
                        if (frame_q <= FW'(1)) begin
                            frame_d = '0;
                            serve_d = 1'b1;
                            state_d = SCORE_PLAY;
                        end else begin
                            frame_d = frame_q - FW'(1);
                        end
                    end
                end
                SCORE_PLAY: begin
                    if (gr_only) begin
                        left_d = left_inc;
                        if (left_inc == WIN_BCD) begin
                            state_d     = SCORE_OVER;
                            game_over_d = 1'b1;
                            winner_d    = 1'b0;
                            blink_d     = BLINK_START;
                        end else begin
                            state_d = SCORE_PAUSE;
                            frame_d = FRAMES_LD;
                        end
                    end else if (gl_only) begin
                        right_d = right_inc;
                        if (right_inc == WIN_BCD) begin
                            state_d     = SCORE_OVER;
                            game_over_d = 1'b1;
                            winner_d    = 1'b1;
                            blink_d     = BLINK_START;
                        end else begin
                            state_d = SCORE_PAUSE;
                            frame_d = FRAMES_LD;
                        end
                    end
                end
                SCORE_OVER: begin
                    if (vb_rise) begin
                        blink_d = blink_q + 6'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        refresh_d = refresh_q + RW'(1);
        idx_d     = idx_q;
        if (refresh_q == REF_MAX) begin
            refresh_d = '0;
            idx_d     = idx_q - 2'd1;
        end
    end

    always_comb begin
        digit = right_q[3:0];
        unique case (idx_q)
            2'd3: digit = left_q[7:4];
            2'd2: digit = left_q[3:0];
            2'd1: digit = right_q[7:4];
            2'd0: digit = right_q[3:0];
        endcase
    end

    seg7_decode u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    assign blank = (state_q == SCORE_OVER) && blink_q[5];

    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_dec;
        if (blank) begin
            an_d  = 4'b1111;
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCORE_IDLE;
            left_q      <= 8'h00;
            right_q     <= 8'h00;
            frame_q     <= '0;
            blink_q     <= '0;
            vblank_q    <= 1'b0;
            refresh_q   <= '0;
            idx_q       <= 2'd0;
            serve_q     <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= 4'b1111;
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            right_q     <= right_d;
            frame_q     <= frame_d;
            blink_q     <= blink_d;
            vblank_q    <= vblank;
            refresh_q   <= refresh_d;
            idx_q       <= idx_d;
            serve_q     <= serve_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign serve     = serve_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule
